// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: slot prescaler, blank/drive sequencing,
// double-buffered display image committed on frame boundaries, optional blinking.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      disp_valid,
  input  logic [4*NUM_DIGITS-1:0]   disp_data,
  input  logic [NUM_DIGITS-1:0]     disp_dp,
  output logic                      disp_ready,
  input  logic                      blink_en,
  output logic [2:0]                digit_sel,
  output logic [NUM_DIGITS-1:0]     digit_en,
  output logic [3:0]                nibble,
  output logic                      dp,
  output logic                      frame_start
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PcntLast      = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] PcntBlankLast = PW'(BLANK_CYCLES - 1);
  localparam logic [2:0]    DigitLast     = 3'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FrameLast     = FW'(BLINK_FRAMES - 1);

  typedef enum logic {StBlank, StDrive} state_e;

  state_e                  state_q, state_d;
  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [2:0]              sel_q, sel_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [3:0]              nibble_q, nibble_d;
  logic                    dp_q, dp_d;
  logic                    fs_q, fs_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIGITS-1:0] shd_data_q, shd_data_d;
  logic [NUM_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic                    pending_q, pending_d;
  logic                    ready_q, ready_d;
  logic                    phase_q, phase_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;

  logic slot_end, frame_end, accept, commit;

  assign slot_end  = (pcnt_q == PcntLast);
  assign frame_end = slot_end && (sel_q == DigitLast);
  assign accept    = disp_valid && ready_q;
  // ready is low whenever pending is set, so accept and commit never coincide
  assign commit    = frame_end && pending_q;

  always_comb begin
    pcnt_d     = slot_end ? '0 : pcnt_q + 1'b1;
    sel_d      = sel_q;
    state_d    = state_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    shd_data_d = shd_data_q;
    shd_dp_d   = shd_dp_q;
    pending_d  = pending_q;
    ready_d    = ready_q;
    fcnt_d     = fcnt_q;
    phase_d    = phase_q;
    nibble_d   = nibble_q;
    dp_d       = dp_q;
    en_d       = '0;
    fs_d       = frame_end;

    if (slot_end) begin
      sel_d = (sel_q == DigitLast) ? 3'd0 : sel_q + 3'd1;
    end

    case (state_q)
      StBlank: if (pcnt_q == PcntBlankLast) state_d = StDrive;
      StDrive: if (slot_end) state_d = StBlank;
      default: state_d = StBlank;
    endcase

    if (commit) begin
      act_data_d = shd_data_q;
      act_dp_d   = shd_dp_q;
      pending_d  = 1'b0;
      ready_d    = 1'b1;
    end
    if (accept) begin
      shd_data_d = disp_data;
      shd_dp_d   = disp_dp;
      pending_d  = 1'b1;
      ready_d    = 1'b0;
    end

    if (frame_end) begin
      if (fcnt_q == FrameLast) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // Post-commit buffer so the first digit of a new frame already shows the new image
    if (slot_end) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (sel_d == 3'(i)) begin
          nibble_d = act_data_d[4*i +: 4];
          dp_d     = act_dp_d[i];
        end
      end
    end

    if (state_d == StDrive && !(blink_en && phase_q)) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        en_d[i] = (sel_d == 3'(i));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StBlank;
      pcnt_q     <= '0;
      sel_q      <= '0;
      en_q       <= '0;
      nibble_q   <= '0;
      dp_q       <= 1'b0;
      fs_q       <= 1'b0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      shd_data_q <= '0;
      shd_dp_q   <= '0;
      pending_q  <= 1'b0;
      ready_q    <= 1'b1;
      phase_q    <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      sel_q      <= sel_d;
      en_q       <= en_d;
      nibble_q   <= nibble_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      shd_data_q <= shd_data_d;
      shd_dp_q   <= shd_dp_d;
      pending_q  <= pending_d;
      ready_q    <= ready_d;
      phase_q    <= phase_d;
      fcnt_q     <= fcnt_d;
    end
  end

  assign disp_ready  = ready_q;
  assign digit_sel   = sel_q;
  assign digit_en    = en_q;
  assign nibble      = nibble_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Randomized bench for seven_seg_scan_ctrl; expected outputs derive from a cycle count
// since reset plus a transaction-level model of the double-buffered image.
module tb_seven_seg_scan_ctrl;

  localparam int P  = 8;
  localparam int B  = 2;
  localparam int N  = 6;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        disp_valid;
  logic [23:0] disp_data;
  logic [5:0]  disp_dp;
  logic        disp_ready;
  logic        blink_en;
  logic [2:0]  digit_sel;
  logic [5:0]  digit_en;
  logic [3:0]  nibble;
  logic        dp;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          cyc;
  logic [23:0] m_act, m_shd;
  logic [5:0]  m_actdp, m_shddp;
  bit          m_pend, m_rdy, m_dark;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (N),
    .PRESCALE    (P),
    .BLANK_CYCLES(B),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_dp    (disp_dp),
    .disp_ready (disp_ready),
    .blink_en   (blink_en),
    .digit_sel  (digit_sel),
    .digit_en   (digit_en),
    .nibble     (nibble),
    .dp         (dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    cyc     = 0;
    m_act   = '0;
    m_shd   = '0;
    m_actdp = '0;
    m_shddp = '0;
    m_pend  = 1'b0;
    m_rdy   = 1'b1;
    m_dark  = 1'b0;
  endtask

  task automatic model_edge();
    bit se, last, cm, acc;
    se   = (cyc % P) == P - 1;
    last = ((cyc / P) % N) == N - 1;
    cm   = se && last && m_pend;
    acc  = disp_valid && m_rdy;
    if (cm) begin
      m_act   = m_shd;
      m_actdp = m_shddp;
      m_pend  = 1'b0;
      m_rdy   = 1'b1;
    end
    if (acc) begin
      m_shd   = disp_data;
      m_shddp = disp_dp;
      m_pend  = 1'b1;
      m_rdy   = 1'b0;
    end
    cyc++;
    m_dark = blink_en && ((((cyc / (P * N)) / BF) % 2) == 1);
  endtask

  task automatic check_outputs();
    int pc, dg;
    logic [5:0] een;
    pc  = cyc % P;
    dg  = (cyc / P) % N;
    een = (pc >= B && !m_dark) ? 6'(1 << dg) : 6'd0;
    check("digit_sel", 32'(digit_sel), 32'(dg));
    check("digit_en", 32'(digit_en), 32'(een));
    check("nibble", 32'(nibble), 32'(m_act[4*dg +: 4]));
    check("dp", 32'(dp), 32'(m_actdp[dg]));
    check("frame_start", 32'(frame_start), 32'(cyc > 0 && (cyc % (P * N)) == 0));
    check("disp_ready", 32'(disp_ready), 32'(m_rdy));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_values();
    check("rst_digit_en", 32'(digit_en), 32'd0);
    check("rst_digit_sel", 32'(digit_sel), 32'd0);
    check("rst_nibble", 32'(nibble), 32'd0);
    check("rst_dp", 32'(dp), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_ready", 32'(disp_ready), 32'd1);
  endtask

  initial begin
    int g;
    reset      = 1'b1;
    disp_valid = 1'b0;
    disp_data  = '0;
    disp_dp    = '0;
    blink_en   = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b0;
    check_outputs();

    // Idle scan
    repeat (100) tick();

    // Mid-frame load
    g = 0;
    while (!(((cyc / P) % N) == 2 && (cyc % P) == 3) && g < 200) begin tick(); g++; end
    check("wait_s2", 32'(g < 200), 32'd1);
    disp_data  = 24'h654321;
    disp_dp    = 6'b000100;
    disp_valid = 1'b1;
    tick();
    disp_valid = 1'b0;
    disp_data  = 24'($urandom);
    repeat (120) tick();

    // Second valid while pending, held until accepted
    disp_valid = 1'b1;
    disp_data  = 24'($urandom);
    disp_dp    = 6'($urandom);
    tick();
    disp_data  = 24'($urandom);
    disp_dp    = 6'($urandom);
    g = 0;
    while (!m_rdy && g < 200) begin tick(); g++; end
    check("wait_s3", 32'(g < 200), 32'd1);
    tick();
    disp_valid = 1'b0;
    repeat (150) tick();

    // Load on the last slot's final cycle with nothing pending
    g = 0;
    while (!((cyc % P) == P - 1 && ((cyc / P) % N) == N - 1 && m_rdy) && g < 200) begin
      tick(); g++;
    end
    check("wait_s4", 32'(g < 200), 32'd1);
    disp_valid = 1'b1;
    disp_data  = 24'($urandom);
    disp_dp    = 6'($urandom);
    tick();
    disp_valid = 1'b0;
    repeat (150) tick();

    // Blink, then drop blink_en inside a dark drive window
    blink_en = 1'b1;
    repeat (4 * P * N + 10) tick();
    g = 0;
    while (!(((((cyc / (P * N)) / BF) % 2) == 1) && (cyc % P) >= B && (cyc % P) <= P - 2)
           && g < 300) begin
      tick(); g++;
    end
    check("wait_s5", 32'(g < 300), 32'd1);
    blink_en = 1'b0;
    repeat (20) tick();

    // Async reset during digit 3 drive with an image pending
    g = 0;
    while (!(m_rdy && ((cyc / P) % N) == 1 && (cyc % P) == 0) && g < 300) begin
      tick(); g++;
    end
    check("wait_s6a", 32'(g < 300), 32'd1);
    disp_valid = 1'b1;
    disp_data  = 24'hABCDEF;
    disp_dp    = 6'b111111;
    tick();
    disp_valid = 1'b0;
    g = 0;
    while (!(((cyc / P) % N) == 3 && (cyc % P) == B + 1) && g < 200) begin tick(); g++; end
    check("wait_s6b", 32'(g < 200), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_values();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_outputs();
    repeat (150) tick();

    // Random traffic
    repeat (2500) begin
      disp_valid = ($urandom % 8) == 0;
      disp_data  = 24'($urandom);
      disp_dp    = 6'($urandom);
      if (($urandom % 150) == 0) blink_en = ~blink_en;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
